scale_pipe_unit: RTL and testbench
==================================

SCALE_PIPE_UNIT -- requirements
Module: scale_pipe_unit

Interface
REQ-001 Parameter WIDTH, default 16, signed sample width per lane (range 8..32).
REQ-002 Parameter LANES, default 8, number of parallel samples per beat (range 1..16).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  unit accepts the input beat this cycle.
REQ-007 mode  input  3  scaling mode, sampled with each accepted beat.
REQ-008 in_data  input  LANES*WIDTH  signed samples; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  output beat present.
REQ-010 out_ready  input  1  downstream accepts the output beat.
REQ-011 out_data  output  LANES*WIDTH  scaled signed samples, same lane packing as in_data.
REQ-012 out_sat  output  1  at least one lane of the current output beat saturated.
REQ-013 clr_count  input  1  synchronous clear of sat_count.
REQ-014 sat_count  output  16  number of output beats with out_sat=1 delivered (out_valid & out_ready).

Function
REQ-015 Mode coding: 000 pass (x1); 001 x0.5; 010 x0.6875 (1/2+1/8+1/16); 011 x0.70703125 (1/2+1/8+1/16+1/64+1/256); 100 x2; 101..111 pass.
REQ-016 Stage 1 forms the exact product per lane as the sum of shifted terms in a WIDTH+10-bit signed value with 8 fraction bits, with no truncation of intermediate terms.
REQ-017 Stage 2 reduces each lane to 8 fraction bits fewer (see REQ-029 for rounding), then saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-018 Latency: an accepted beat appears on out_data exactly 2 cycles after acceptance when out_ready is held at 1.
REQ-019 Throughput: one beat per cycle when out_ready=1.
REQ-020 Pipeline: 2 register stages (s1, s2), each with its own valid bit; a stage loads when it is empty or its contents move downstream in the same cycle.
REQ-021 in_ready = !s1_valid | !s2_valid | out_ready. This is a combinational path from out_ready, and no beat is ever dropped or duplicated.
REQ-022 out_valid = s2_valid, and out_data/out_sat hold stable while out_valid=1 and out_ready=0.
REQ-023 Mode travels with its beat: a mode change between consecutive beats affects only the beats accepted with it.
REQ-024 sat_count increments by 1 per delivered beat with out_sat=1, saturates at 0xFFFF with no wrap, and clr_count=1 forces 0 (clear wins over a simultaneous increment).

Reset
REQ-025 While rst_n=0 at a clock edge: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sat=0, sat_count=0.
REQ-026 in_ready is 1 during and immediately after reset (pipeline empty).
REQ-027 Reset asserted mid-stream discards all in-flight beats, and no partial beat is emitted after reset release.

Configuration
REQ-028 Macro SCALE_PIPE_ROUND_EN selects the stage-2 reduction rule.
REQ-029 With SCALE_PIPE_ROUND_EN defined: round half toward +infinity (add 2^7, then arithmetic shift right by 8). Without it: truncate toward -infinity (arithmetic shift right by 8). Saturation is identical in both builds.

Verification
REQ-030 WIDTH=16, mode 010, x=100, out_ready=1: output 69 if SCALE_PIPE_ROUND_EN, else 68, valid exactly 2 cycles after acceptance, out_sat=0.
REQ-031 Mode 001, x=-3: output -1 if SCALE_PIPE_ROUND_EN, else -2; mode 011, x=-32768: output -23168 in both builds.
REQ-032 Mode 100, lane0=20000, lane1=-20000, others 5: outputs 32767, -32768, 10 with out_sat=1; sat_count reaches 1 after delivery and returns to 0 on clr_count.
REQ-033 Stream 10 beats while out_ready toggles 1,0,0,1 repeating: all 10 beats emerge in order with no loss or duplication, and out_data is stable during stalls.
REQ-034 Assert rst_n=0 with both stages full and out_ready=0: out_valid=0 on the next cycle, and after release the first output is the first post-reset beat.
REQ-035 Apply 65540 saturating beats: sat_count holds at 0xFFFF; clr_count and a saturating delivery in the same cycle yield 0.

Source files
------------

// File: rtl/scale_pipe_unit.sv
// Two-stage per-lane constant scaler with valid/ready flow control and a saturation event counter.
// Define SCALE_PIPE_ROUND_EN for round-half-up reduction; the default build truncates toward -infinity.
module scale_pipe_unit #(
    parameter int WIDTH = 16,
    parameter int LANES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               mode,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     out_sat,
    input  logic                     clr_count,
    output logic [15:0]              sat_count
);

    // Product width: 8 fraction bits plus headroom for the x2 mode.
    localparam int PW = WIDTH + 10;

`ifdef SCALE_PIPE_ROUND_EN
    localparam logic signed [PW-1:0] RND_BIAS = PW'(128);
`else
    localparam logic signed [PW-1:0] RND_BIAS = '0;
`endif

    localparam logic signed [PW-1:0]    SAT_MAX = {{11{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    SAT_MIN = {{11{1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]        OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic                   s1_valid_reg;
    logic [LANES*PW-1:0]    s1_prod_reg;
    logic [LANES*PW-1:0]    s1_prod_next;
    logic                   s2_valid_reg;
    logic [LANES*WIDTH-1:0] s2_data_reg;
    logic [LANES*WIDTH-1:0] s2_data_next;
    logic                   s2_sat_reg;
    logic [LANES-1:0]       lane_sat;
    logic [15:0]            sat_count_reg;

    logic s2_load;
    logic accept;
    logic deliver;

    assign s2_load   = !s2_valid_reg || out_ready;
    assign in_ready  = !s1_valid_reg || s2_load;
    assign accept    = in_valid && in_ready;
    assign deliver   = s2_valid_reg && out_ready;

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_sat   = s2_sat_reg;
    assign sat_count = sat_count_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [PW-1:0] x_ext;
            logic signed [PW-1:0] prod;
            logic signed [PW-1:0] biased;
            logic signed [PW-1:0] shifted;
            logic [WIDTH-1:0]     lane_out;
            logic                 lane_sat_bit;

            assign x_ext = {{10{in_data[gi*WIDTH+WIDTH-1]}}, in_data[gi*WIDTH +: WIDTH]};

            // Exact product with 8 fraction bits, built from shifted copies of x.
            always_comb begin
                prod = x_ext <<< 8;
                case (mode)
                    3'b001:  prod = x_ext <<< 7;
                    3'b010:  prod = (x_ext <<< 7) + (x_ext <<< 5) + (x_ext <<< 4);
                    3'b011:  prod = (x_ext <<< 7) + (x_ext <<< 5) + (x_ext <<< 4)
                                  + (x_ext <<< 2) + x_ext;
                    3'b100:  prod = x_ext <<< 9;
                    default: prod = x_ext <<< 8;
                endcase
            end

            assign s1_prod_next[gi*PW +: PW] = prod;

            assign biased  = signed'(s1_prod_reg[gi*PW +: PW]) + RND_BIAS;
            assign shifted = biased >>> 8;

            always_comb begin
                lane_out     = shifted[WIDTH-1:0];
                lane_sat_bit = 1'b0;
                if (shifted > SAT_MAX) begin
                    lane_out     = OUT_MAX;
                    lane_sat_bit = 1'b1;
                end else if (shifted < SAT_MIN) begin
                    lane_out     = OUT_MIN;
                    lane_sat_bit = 1'b1;
                end
            end

            assign s2_data_next[gi*WIDTH +: WIDTH] = lane_out;
            assign lane_sat[gi]                    = lane_sat_bit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_prod_reg   <= '0;
            s2_valid_reg  <= 1'b0;
            s2_data_reg   <= '0;
            s2_sat_reg    <= 1'b0;
            sat_count_reg <= '0;
        end else begin
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_prod_reg  <= s1_prod_next;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_data_reg <= s2_data_next;
                    s2_sat_reg  <= |lane_sat;
                end
            end

            // Clear takes priority; the count sticks at all-ones.
            if (clr_count) begin
                sat_count_reg <= '0;
            end else if (deliver && s2_sat_reg && (sat_count_reg != 16'hFFFF)) begin
                sat_count_reg <= sat_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_scale_pipe_unit.sv
// Directed-vector bench for scale_pipe_unit (WIDTH=16, LANES=8); expectations follow the
// build's reduction rule via SCALE_PIPE_ROUND_EN.
module tb_scale_pipe_unit;
    localparam int W  = 16;
    localparam int L  = 8;
    localparam int DW = W * L;

`ifdef SCALE_PIPE_ROUND_EN
    localparam logic signed [W-1:0] EXP_M2_100 = 16'sd69;
    localparam logic signed [W-1:0] EXP_M1_N3  = -16'sd1;
`else
    localparam logic signed [W-1:0] EXP_M2_100 = 16'sd68;
    localparam logic signed [W-1:0] EXP_M1_N3  = -16'sd2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    mode = 3'b000;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_sat;
    logic          clr_count = 1'b0;
    logic [15:0]   sat_count;

    int checks = 0;
    int failures = 0;

    scale_pipe_unit #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .clr_count (clr_count),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] splat(input logic signed [W-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] beat(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = W'(k * 256 + i + 1);
        return r;
    endfunction

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] e;
        logic [DW-1:0] prev;
        logic          stalled;
        int            sent;
        int            got;
        int            delivered;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", DW'(out_valid), DW'(1'b0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sat", DW'(out_sat), DW'(1'b0));
        chk("rst_sat_count", DW'(sat_count), DW'(16'd0));
        chk("rst_in_ready", DW'(in_ready), DW'(1'b1));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", DW'(in_ready), DW'(1'b1));

        // x0.6875 of 100, two-cycle latency
        mode = 3'b010; in_data = splat(16'sd100); in_valid = 1'b1;
        #1 chk("m2_in_ready", DW'(in_ready), DW'(1'b1));
        @(negedge clk); in_valid = 1'b0;
        chk("m2_lat1_valid", DW'(out_valid), DW'(1'b0));
        @(negedge clk);
        chk("m2_lat2_valid", DW'(out_valid), DW'(1'b1));
        chk("m2_data", out_data, splat(EXP_M2_100));
        chk("m2_sat", DW'(out_sat), DW'(1'b0));
        $display("beat m2 out=%h", out_data);
        @(negedge clk);
        chk("m2_no_dup", DW'(out_valid), DW'(1'b0));

        // Back-to-back beats with different modes
        mode = 3'b001; in_data = splat(-16'sd3); in_valid = 1'b1;
        @(negedge clk); mode = 3'b011; in_data = splat(-16'sd32768);
        @(negedge clk); in_valid = 1'b0;
        chk("m1_valid", DW'(out_valid), DW'(1'b1));
        chk("m1_data", out_data, splat(EXP_M1_N3));
        $display("beat m1 out=%h", out_data);
        @(negedge clk);
        chk("m3_valid", DW'(out_valid), DW'(1'b1));
        chk("m3_data", out_data, splat(-16'sd23168));
        $display("beat m3 out=%h", out_data);
        mode = 3'b101; in_data = splat(-16'sd7); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("m5_data", out_data, splat(-16'sd7));
        $display("beat m5 out=%h", out_data);

        // x2 with saturation in both directions, counter and clear
        v = splat(16'sd5); v[0 +: W] = 16'sd20000; v[W +: W] = -16'sd20000;
        e = splat(16'sd10); e[0 +: W] = 16'sh7FFF; e[W +: W] = 16'sh8000;
        mode = 3'b100; in_data = v; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("m4_data", out_data, e);
        chk("m4_sat", DW'(out_sat), DW'(1'b1));
        chk("m4_cnt_before", DW'(sat_count), DW'(16'd0));
        $display("beat m4 out=%h sat=%0d", out_data, out_sat);
        @(negedge clk);
        chk("m4_cnt_after", DW'(sat_count), DW'(16'd1));
        clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        chk("m4_cnt_clr", DW'(sat_count), DW'(16'd0));

        // Stream 10 beats with out_ready pattern 1,0,0,1
        sent = 0; got = 0; stalled = 1'b0; prev = '0; mode = 3'b000;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 10);
            in_data   = beat(sent);
            #1;
            if (stalled) begin
                chk("stall_valid", DW'(out_valid), DW'(1'b1));
                chk("stall_hold", out_data, prev);
            end
            if (out_valid && out_ready) begin
                chk("stream_beat", out_data, beat(got));
                $display("beat stream %0d out=%h", got, out_data);
                got++;
            end
            stalled = out_valid && !out_ready;
            prev = out_data;
            if (in_valid && in_ready) sent++;
        end
        chk("stream_count", DW'(got), DW'(10));
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_empty", DW'(out_valid), DW'(1'b0));

        // Reset with both stages full and downstream stalled
        out_ready = 1'b0; in_valid = 1'b1; in_data = beat(50);
        @(negedge clk); in_data = beat(51);
        @(negedge clk); in_valid = 1'b0;
        #1 chk("full_in_ready", DW'(in_ready), DW'(1'b0));
        chk("full_out_valid", DW'(out_valid), DW'(1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", DW'(out_valid), DW'(1'b0));
        chk("midrst_data", out_data, '0);
        chk("midrst_in_ready", DW'(in_ready), DW'(1'b1));
        rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = beat(60);
        @(negedge clk); in_valid = 1'b0;
        chk("postrst_lat1", DW'(out_valid), DW'(1'b0));
        @(negedge clk);
        chk("postrst_valid", DW'(out_valid), DW'(1'b1));
        chk("postrst_data", out_data, beat(60));
        $display("beat postrst out=%h", out_data);
        @(negedge clk);
        chk("postrst_no_stale", DW'(out_valid), DW'(1'b0));

        // Long saturating stream: counter saturation, then clear racing a delivery
        clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        mode = 3'b100; in_data = splat(16'sd20000); in_valid = 1'b1; out_ready = 1'b1;
        delivered = 0;
        for (int i = 0; i < 65540; i++) begin
            @(negedge clk);
            if (i == 1000) chk("cnt_mid", DW'(sat_count), DW'(16'd999));
        end
        chk("cnt_hold", DW'(sat_count), DW'(16'hFFFF));
        chk("race_valid", DW'(out_valid), DW'(1'b1));
        chk("race_sat", DW'(out_sat), DW'(1'b1));
        clr_count = 1'b1;
        @(negedge clk); clr_count = 1'b0;
        chk("cnt_clr_race", DW'(sat_count), DW'(16'd0));
        @(negedge clk);
        chk("cnt_restart", DW'(sat_count), DW'(16'd1));
        $display("beat satstream count=%0d", sat_count);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
